// File: rtl/banked_register_file.sv
// General-purpose register bank: three registered read ports, one write port, PC at the top index,
// and per-mode shadow copies of the upper registers. Define REGFILE_BYPASS_EN for write-first reads.
module banked_register_file #(
  parameter  int WIDTH     = 32,
  parameter  int DIR       = 4,
  parameter  int NUM_BANKS = 2,
  parameter  int BANKED_LO = 13,
  parameter  int PC_INC    = 4,
  localparam int MW        = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIR-1:0]   da,
  input  logic [DIR-1:0]   db,
  input  logic [DIR-1:0]   dc,
  input  logic             re,
  input  logic [DIR-1:0]   address,
  input  logic [WIDTH-1:0] write_data,
  input  logic             we,
  input  logic [MW-1:0]    mode,
  input  logic [WIDTH-1:0] pc_in,
  input  logic             pc_we,
  input  logic             pc_inc,
  output logic [WIDTH-1:0] doa,
  output logic [WIDTH-1:0] dob,
  output logic [WIDTH-1:0] doc,
  output logic             rvalid,
  output logic [WIDTH-1:0] pc_out
);

  localparam int             TOP_IDX = 2**DIR - 1;
  localparam logic [DIR-1:0] PC_IDX  = DIR'(TOP_IDX);
  localparam logic [DIR-1:0] LO_IDX  = DIR'(BANKED_LO);

  logic [WIDTH-1:0] shared_q [0:BANKED_LO-1];
  logic [WIDTH-1:0] banked_q [0:NUM_BANKS-1][BANKED_LO:TOP_IDX-1];
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] pc_rd;
  logic [MW-1:0]    bank_sel;
  logic             wr_shared;
  logic             wr_banked;

  // Out-of-range modes fall back to the user bank.
  assign bank_sel  = (int'(mode) < NUM_BANKS) ? mode : '0;
  assign wr_shared = we && (address < LO_IDX);
  assign wr_banked = we && (address >= LO_IDX) && (address != PC_IDX);

  always_comb begin
    // NOTE: default assignment first so no path through this block can infer a latch.
    pc_next = pc_q;
    if (we && address == PC_IDX) pc_next = write_data;
    else if (pc_we)              pc_next = pc_in;
    else if (pc_inc)             pc_next = pc_q + WIDTH'(PC_INC);
  end

`ifdef REGFILE_BYPASS_EN
  assign pc_rd = pc_next;
`else
  assign pc_rd = pc_q;
`endif

  function automatic logic [WIDTH-1:0] read_port(input logic [DIR-1:0] a);
    logic [WIDTH-1:0] v;
    if (a == PC_IDX)     v = pc_rd;
    else if (a < LO_IDX) v = shared_q[a];
    else                 v = banked_q[bank_sel][a];
`ifdef REGFILE_BYPASS_EN
    // Mode is shared by both ports, so equal addresses always resolve to the same copy.
    if (we && a == address && a != PC_IDX) v = write_data;
`endif
    return v;
  endfunction

  // NOTE: every storage element is reset, including the register arrays, because software
  // relies on all registers reading zero after reset; this rules out RAM-macro mapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BANKED_LO; i++) shared_q[i] <= '0;
      for (int b = 0; b < NUM_BANKS; b++)
        for (int i = BANKED_LO; i < TOP_IDX; i++) banked_q[b][i] <= '0;
      pc_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (wr_shared) shared_q[address] <= write_data;
      if (wr_banked) banked_q[bank_sel][address] <= write_data;
      pc_q <= pc_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      doa    <= '0;
      dob    <= '0;
      doc    <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= re;
      if (re) begin
        doa <= read_port(da);
        dob <= read_port(db);
        doc <= read_port(dc);
      end
    end
  end

  assign pc_out = pc_q;

endmodule
